// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: requester ports and AXI read-master port of the read arbiter
interface axi_rd_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  if_gnt_o;
    logic                  if_rsp_valid_o;
    logic [31:0]           if_rdata_o;
    logic                  mem_req_i;
    logic [ADDR_WIDTH-1:0] mem_addr_i;
    logic [1:0]            mem_size_i;
    logic                  mem_signed_i;
    logic                  mem_gnt_o;
    logic                  mem_rsp_valid_o;
    logic [63:0]           mem_rdata_o;
    logic                  rd_addr_valid_o;
    logic [ADDR_WIDTH-1:0] rd_addr_o;
    logic [1:0]            rd_size_o;
    logic                  rd_data_valid_i;
    logic [DATA_WIDTH-1:0] rd_data_i;

    modport slave (
        input  if_req_i, if_addr_i, mem_req_i, mem_addr_i, mem_size_i, mem_signed_i,
        input  rd_data_valid_i, rd_data_i,
        output if_gnt_o, if_rsp_valid_o, if_rdata_o,
        output mem_gnt_o, mem_rsp_valid_o, mem_rdata_o,
        output rd_addr_valid_o, rd_addr_o, rd_size_o
    );

    modport master (
        output if_req_i, if_addr_i, mem_req_i, mem_addr_i, mem_size_i, mem_signed_i,
        output rd_data_valid_i, rd_data_i,
        input  if_gnt_o, if_rsp_valid_o, if_rdata_o,
        input  mem_gnt_o, mem_rsp_valid_o, mem_rdata_o,
        input  rd_addr_valid_o, rd_addr_o, rd_size_o
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin IF/MEM read arbiter issuing one read at a time with load extension
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input logic              clk,
    input logic              rst,
    axi_rd_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] BUSY_IF  = 2'd1;
    localparam logic [1:0] BUSY_MEM = 2'd2;
    localparam logic [1:0] RESP     = 2'd3;

    logic [1:0]            state;
    logic                  last_mem;
    logic                  signed_q;
    logic [DATA_WIDTH-1:0] rd_d;
    logic [63:0]           ld;
    logic [63:0]           ld_ext;

    assign rd_d = bus.rd_data_i;
    assign ld   = rd_d[63:0];

    // grant only in IDLE; on conflict the port not granted last wins
    always_comb begin
        bus.if_gnt_o  = state == IDLE && bus.if_req_i && (!bus.mem_req_i || last_mem);
        bus.mem_gnt_o = state == IDLE && bus.mem_req_i && (!bus.if_req_i || !last_mem);
    end

    // width select and sign/zero extension of load data using the size held on the bus
    always_comb begin
        ld_ext = bus.rd_size_o == 2'd0 ? {{56{signed_q & ld[7]}}, ld[7:0]} :
                 bus.rd_size_o == 2'd1 ? {{48{signed_q & ld[15]}}, ld[15:0]} :
                 bus.rd_size_o == 2'd2 ? {{32{signed_q & ld[31]}}, ld[31:0]} : ld;
    end

    // transaction sequencing: capture request on grant, hold it until data, pulse response
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            last_mem            <= 1'b0;
            signed_q            <= 1'b0;
            bus.rd_addr_valid_o <= 1'b0;
            bus.rd_addr_o       <= {ADDR_WIDTH{1'b0}};
            bus.rd_size_o       <= 2'd0;
            bus.if_rsp_valid_o  <= 1'b0;
            bus.mem_rsp_valid_o <= 1'b0;
            bus.if_rdata_o      <= 32'd0;
            bus.mem_rdata_o     <= 64'd0;
        end else begin
            bus.if_rsp_valid_o  <= 1'b0;
            bus.mem_rsp_valid_o <= 1'b0;
            if (bus.if_gnt_o || bus.mem_gnt_o) begin
                bus.rd_addr_o       <= bus.mem_gnt_o ? bus.mem_addr_i : bus.if_addr_i;
                bus.rd_size_o       <= bus.mem_gnt_o ? bus.mem_size_i : 2'b10;
                signed_q            <= bus.mem_gnt_o ? bus.mem_signed_i : signed_q;
                last_mem            <= bus.mem_gnt_o;
                bus.rd_addr_valid_o <= 1'b1;
                state               <= bus.mem_gnt_o ? BUSY_MEM : BUSY_IF;
            end else if ((state == BUSY_IF || state == BUSY_MEM) && bus.rd_data_valid_i) begin
                bus.rd_addr_valid_o <= 1'b0;
                state               <= RESP;
                if (state == BUSY_IF) begin
                    bus.if_rsp_valid_o <= 1'b1;
                    bus.if_rdata_o     <= ld[31:0];
                end else begin
                    bus.mem_rsp_valid_o <= 1'b1;
                    bus.mem_rdata_o     <= ld_ext;
                end
            end else if (state == RESP) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: randomized self-checking bench against a transaction-level arbiter model
module tb_axi_rd_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    bit   last_mem;
    logic [63:0] exp_if;
    logic [63:0] exp_mem;

    axi_rd_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    axi_rd_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] load_model(input logic [1:0] sz, input bit sg, input logic [63:0] d);
        int          w;
        logic [63:0] mask;
        logic [63:0] f;
        w    = 8 << sz;
        mask = (w == 64) ? {64{1'b1}} : (64'd1 << w) - 64'd1;
        f    = d & mask;
        if (sg && w < 64 && f[w-1])
            f = f | ~mask;
        return f;
    endfunction

    task automatic scramble_inputs();
        bus.if_req_i     = 1'($urandom);
        bus.mem_req_i    = 1'($urandom);
        bus.if_addr_i    = rnd64();
        bus.mem_addr_i   = rnd64();
        bus.mem_size_i   = 2'($urandom);
        bus.mem_signed_i = 1'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr_valid"}, bus.rd_addr_valid_o, 0);
        chk({tag, "_addr"}, bus.rd_addr_o, 0);
        chk({tag, "_size"}, bus.rd_size_o, 0);
        chk({tag, "_rsp"}, {bus.if_rsp_valid_o, bus.mem_rsp_valid_o}, 0);
        chk({tag, "_if_rdata"}, bus.if_rdata_o, 0);
        chk({tag, "_mem_rdata"}, bus.mem_rdata_o, 0);
    endtask

    // one full transaction starting at the beginning of an IDLE cycle; ends at the next IDLE cycle
    task automatic do_txn(input bit ir, input bit mr, input logic [63:0] ia, input logic [63:0] ma,
                          input logic [1:0] sz, input bit sg, input logic [63:0] data, input int dly);
        bit          wm;
        logic [63:0] ea;
        logic [1:0]  es;
        bus.if_req_i        = ir;
        bus.mem_req_i       = mr;
        bus.if_addr_i       = ia;
        bus.mem_addr_i      = ma;
        bus.mem_size_i      = sz;
        bus.mem_signed_i    = sg;
        bus.rd_data_valid_i = 1'($urandom);
        bus.rd_data_i       = rnd64();
        wm = mr && (!ir || !last_mem);
        ea = wm ? ma : ia;
        es = wm ? sz : 2'd2;
        @(negedge clk);
        chk("if_gnt", bus.if_gnt_o, !wm);
        chk("mem_gnt", bus.mem_gnt_o, wm);
        chk("idle_addr_valid", bus.rd_addr_valid_o, 0);
        chk("idle_rsp", {bus.if_rsp_valid_o, bus.mem_rsp_valid_o}, 0);
        last_mem = wm;
        for (int i = 0; i <= dly; i++) begin
            @(posedge clk); #1;
            scramble_inputs();
            bus.rd_data_valid_i = (i == dly);
            bus.rd_data_i       = (i == dly) ? data : rnd64();
            @(negedge clk);
            chk("busy_addr_valid", bus.rd_addr_valid_o, 1);
            chk("busy_addr", bus.rd_addr_o, ea);
            chk("busy_size", bus.rd_size_o, es);
            chk("busy_gnt", {bus.if_gnt_o, bus.mem_gnt_o}, 0);
            chk("busy_rsp", {bus.if_rsp_valid_o, bus.mem_rsp_valid_o}, 0);
            chk("if_rdata_hold", bus.if_rdata_o, exp_if);
            chk("mem_rdata_hold", bus.mem_rdata_o, exp_mem);
        end
        if (wm)
            exp_mem = load_model(sz, sg, data);
        else
            exp_if = {32'd0, data[31:0]};
        @(posedge clk); #1;
        scramble_inputs();
        bus.rd_data_valid_i = 1'($urandom);
        bus.rd_data_i       = rnd64();
        @(negedge clk);
        chk("valid_release", bus.rd_addr_valid_o, 0);
        chk("if_rsp", bus.if_rsp_valid_o, !wm);
        chk("mem_rsp", bus.mem_rsp_valid_o, wm);
        chk("if_rdata", bus.if_rdata_o, exp_if);
        chk("mem_rdata", bus.mem_rdata_o, exp_mem);
        chk("resp_gnt", {bus.if_gnt_o, bus.mem_gnt_o}, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        last_mem = 1'b0;
        exp_if   = 64'd0;
        exp_mem  = 64'd0;
        rst      = 1'b1;
        bus.if_req_i = 1'b0; bus.mem_req_i = 1'b0; bus.if_addr_i = '0; bus.mem_addr_i = '0;
        bus.mem_size_i = 2'd0; bus.mem_signed_i = 1'b0; bus.rd_data_valid_i = 1'b0; bus.rd_data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        chk("reset_gnt", {bus.if_gnt_o, bus.mem_gnt_o}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // simultaneous requests: MEM, IF, MEM, IF
        for (int k = 0; k < 4; k++)
            do_txn(1, 1, rnd64(), rnd64(), 2'($urandom), 1'($urandom), rnd64(), k);

        // IF only
        do_txn(1, 0, 64'h8000_0004, rnd64(), 2'd0, 1'b0, 64'hDEAD_BEEF_0000_0013, 2);
        // byte loads, signed and unsigned
        do_txn(0, 1, rnd64(), 64'h1000, 2'd0, 1'b1, 64'h1234_5678_9ABC_DE80, 1);
        do_txn(0, 1, rnd64(), 64'h1000, 2'd0, 1'b0, 64'h1234_5678_9ABC_DE80, 0);
        // half-word signed and double signed
        do_txn(0, 1, rnd64(), 64'h2002, 2'd1, 1'b1, 64'h0000_0000_1234_8001, 3);
        do_txn(0, 1, rnd64(), 64'h3008, 2'd3, 1'b1, 64'h8000_0000_0000_0001, 1);
        // word signed
        do_txn(0, 1, rnd64(), 64'h4004, 2'd2, 1'b1, 64'h0123_4567_8765_4321, 0);

        // reset in BUSY_MEM, then a stray data pulse in IDLE
        bus.if_req_i = 1'b0; bus.mem_req_i = 1'b1; bus.mem_addr_i = 64'h5555; bus.mem_size_i = 2'd3;
        bus.rd_data_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_pre_gnt", bus.mem_gnt_o, 1);
        @(posedge clk); #1;
        bus.mem_req_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_pre_busy", bus.rd_addr_valid_o, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        last_mem = 1'b0;
        exp_if   = 64'd0;
        exp_mem  = 64'd0;
        @(negedge clk);
        chk_all_zero("midrst");
        @(posedge clk); #1;
        bus.rd_data_valid_i = 1'b1;
        bus.rd_data_i       = rnd64();
        @(negedge clk);
        chk("stray_gnt", {bus.if_gnt_o, bus.mem_gnt_o}, 0);
        @(posedge clk); #1;
        bus.rd_data_valid_i = 1'b0;
        @(negedge clk);
        chk_all_zero("stray");
        @(posedge clk); #1;
        do_txn(1, 1, rnd64(), rnd64(), 2'd2, 1'b0, rnd64(), 1);
        do_txn(1, 0, rnd64(), rnd64(), 2'd0, 1'b0, rnd64(), 0);

        // randomized traffic with occasional idle cycles carrying stray data
        for (int n = 0; n < 200; n++) begin
            int r;
            if ($urandom_range(0, 3) == 0) begin
                bus.if_req_i = 1'b0; bus.mem_req_i = 1'b0;
                bus.rd_data_valid_i = 1'($urandom);
                bus.rd_data_i = rnd64();
                @(negedge clk);
                chk("idle_gnt", {bus.if_gnt_o, bus.mem_gnt_o}, 0);
                chk("idle_rsp", {bus.if_rsp_valid_o, bus.mem_rsp_valid_o}, 0);
                @(posedge clk); #1;
            end
            r = $urandom_range(1, 3);
            do_txn(r[0], r[1], rnd64(), rnd64(), 2'($urandom), 1'($urandom), rnd64(), $urandom_range(0, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Arbitrates between the instruction-fetch (IF) read port and the load-unit (MEM) read port.
- Issues one read at a time to the single AXI read master.
- Holds the address and size of the request in flight stable until the master returns data.
- Routes the right-aligned read data back to the winning requester, with width selection and sign/zero extension for loads.

Parameters:
- ADDR_WIDTH, 64, request address width.
- DATA_WIDTH, 64, read data width from the AXI read master.

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- if_req_i  in  1  IF read request (level, held until granted)
- if_addr_i  in  ADDR_WIDTH  IF fetch address
- if_gnt_o  out  1  IF request accepted this cycle
- if_rsp_valid_o  out  1  IF data valid (1-cycle pulse)
- if_rdata_o  out  32  fetched instruction
- mem_req_i  in  1  MEM read request (level, held until granted)
- mem_addr_i  in  ADDR_WIDTH  load address
- mem_size_i  in  2  load size: 0=B, 1=H, 2=W, 3=D
- mem_signed_i  in  1  1 = sign-extend the result, 0 = zero-extend
- mem_gnt_o  out  1  MEM request accepted this cycle
- mem_rsp_valid_o  out  1  MEM data valid (1-cycle pulse)
- mem_rdata_o  out  64  extended load data
- rd_addr_valid_o  out  1  read request to the AXI read master
- rd_addr_o  out  ADDR_WIDTH  read address to the master
- rd_size_o  out  2  read size to the master
- rd_data_valid_i  in  1  master data-return pulse
- rd_data_i  in  DATA_WIDTH  master read data, right-aligned to bit 0

Behaviour:
- States: IDLE, BUSY_IF, BUSY_MEM, RESP. Reset enters IDLE.
- Reset values:
  - Outputs: all rsp_valid, rd_addr_valid_o, rd_addr_o, rd_size_o, if_rdata_o and mem_rdata_o are 0.
  - Internal: last-grant register = IF, so MEM wins the first conflict.
- Grant (IDLE only; gnt outputs are combinational):
  - Only if_req_i high: if_gnt_o = 1.
  - Only mem_req_i high: mem_gnt_o = 1.
  - Both high: round-robin; the port not granted last wins.
  - At most one gnt is high per cycle. gnt is always 0 outside IDLE.
- On grant:
  - Capture the address into rd_addr_o.
  - Capture size: IF uses size 2'b10; MEM uses mem_size_i.
  - MEM also captures mem_signed_i.
  - Update last-grant.
  - Next state: BUSY_IF or BUSY_MEM.
- BUSY_x:
  - rd_addr_valid_o = 1 (registered). rd_addr_o and rd_size_o are held constant.
  - Requester inputs are ignored after grant; requesters may present their next request immediately.
- rd_data_valid_i in BUSY_x (captured on the same edge):
  - Register rd_data_i into the selected rdata output.
  - Set that port's rsp_valid_o = 1 for exactly 1 cycle.
  - Clear rd_addr_valid_o.
  - Go to RESP.
  - This guarantees rd_addr_valid_o is low no later than 1 cycle after the master's data pulse, so the master does not re-issue.
- RESP: rsp_valid_o is high this cycle; next state IDLE. No grant is issued in RESP.
- Latency:
  - Grant at cycle G, rd_addr_valid_o high from G+1.
  - rsp_valid_o high at cycle D+1, where D is the cycle rd_data_valid_i is seen.
  - Minimum gap between successive grants: RESP plus IDLE.
- IF data: if_rdata_o = rd_data_i[31:0].
- MEM data (ext = sign bit of the field when signed, else 0):
  - B: {56{ext}, d[7:0]}
  - H: {48{ext}, d[15:0]}
  - W: {32{ext}, d[31:0]}
  - D: d[63:0], unchanged regardless of signed.
- rdata outputs hold their last value until overwritten by the next response for the same port.
- rd_data_valid_i in IDLE or RESP: ignored; no state change, no rsp pulse.
- Reset mid-transaction: abandon the transaction, return to IDLE, clear all outputs, discard any later data pulse. The master shares rst.
- A requester dropping req before gnt is legal; the request is simply not taken.

Test Plan:
- IF only:
  - Stimulus: if_req at cycle 0 with addr 0x8000_0004; master returns 0x0000_0013 2 cycles after valid.
  - Required: if_gnt at cycle 0; rd_addr_valid_o cycles 1..D; rd_addr_o = 0x8000_0004; rd_size_o = 2; if_rsp_valid 1-cycle pulse with if_rdata = 0x13; mem_rsp_valid stays 0.
- Signed byte load:
  - Stimulus: mem_size = 0, signed = 1, data 0x..._0080.
  - Required: mem_rdata = 0xFFFF_FFFF_FFFF_FF80. Same data with signed = 0 gives 0x80.
- Half-word and double:
  - Half-word signed: data 0x1234_8001 → 0xFFFF_FFFF_FFFF_8001.
  - Double: data 0x8000_0000_0000_0001 → passthrough with signed = 1.
- Simultaneous requests for 4 transactions:
  - Stimulus: if_req and mem_req held high.
  - Required: grants in order MEM, IF, MEM, IF; never both gnt in one cycle; each rsp goes to the correct port.
- Address stability and valid release:
  - Stimulus: change if_addr_i and mem_addr_i every cycle during BUSY.
  - Required: rd_addr_o is constant during BUSY; rd_addr_valid_o is 0 in the cycle after rd_data_valid_i; no re-grant in RESP.
- Reset in BUSY_MEM and stray data:
  - Stimulus: assert rst during BUSY_MEM; then send a stray rd_data_valid_i in IDLE.
  - Required: all outputs 0 after rst; no rsp pulse from the stray data; the next if_req is granted normally.
